ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk input 1: pipeline clock; all state updates on rising edge.
REQ-002 rst input 1: reset, synchronous, active-high; clock clk.
REQ-003 regwriteE, memwriteE, jumpE, branchE, alusrcE input 1 each: control bits from the ID/EX register.
REQ-004 resultsrcE input 2: result-select code from ID/EX; alucontrolE input 3: ALU operation code.
REQ-005 pcE, pcplus4E, rd1E, rd2E, immextendE input 32 each: PC, PC+4, register operands and extended immediate from ID/EX.
REQ-006 rdE input 5: destination register number.
REQ-007 forwardAE, forwardBE input 2 each: operand-A and operand-B forwarding selects from the hazard unit.
REQ-008 aluresultM_fwd, resultW input 32 each: forwarding values from the MEM and WB stages.
REQ-009 flushM input 1: squashes the instruction entering EX/MEM.
REQ-010 pcsrcE output 1: PC redirect request (combinational); pctargetE output 32: redirect target (combinational).
REQ-011 regwriteM, memwriteM output 1 each; resultsrcM output 2: registered control bits.
REQ-012 aluresultM, writedataM, pcplus4M output 32 each; rdM output 5: registered EX/MEM data.

Function
REQ-013 Operand A SHALL be selected by forwardAE: 00 rd1E, 01 resultW, 10 aluresultM_fwd, 11 rd1E.
REQ-014 The forwarded operand B value SHALL be selected by forwardBE using the same encoding applied to rd2E.
REQ-015 srcB SHALL be immextendE when alusrcE=1, else the forwarded operand B value.
REQ-016 The ALU SHALL compute, mod 2^32: 000 A+B; 001 A-B; 010 A&B; 011 A|B; 101 {31'b0, signed(A)<signed(B)}; any other code yields 0.
REQ-017 zero SHALL be 1 if and only if the 32-bit ALU result equals 0 (combinational).
REQ-018 pctargetE SHALL equal pcE+immextendE truncated to 32 bits, wrap-around permitted.
REQ-019 pcsrcE SHALL equal (branchE & zero) | jumpE, combinational in the same cycle.
REQ-020 On each rising edge without rst, the EX/MEM register SHALL capture the ALU result into aluresultM and the forwarded operand B value (not srcB) into writedataM.
REQ-021 On that same edge it SHALL also capture pcplus4E, rdE, regwriteE, memwriteE and resultsrcE into the corresponding M outputs.
REQ-022 Pipeline latency SHALL be 1 cycle from the E inputs to the M outputs.
REQ-023 When flushM=1 at an edge, regwriteM, memwriteM and resultsrcM SHALL load 0, while data fields load normally.
REQ-024 rst SHALL take priority over flushM.
REQ-025 A write of a result to x0 (rdE=0) SHALL pass through unchanged; x0 suppression happens in the register file.

Reset
REQ-026 While rst=1 at a rising edge, every registered output (regwriteM, memwriteM, resultsrcM, aluresultM, writedataM, pcplus4M, rdM) SHALL become 0 on that edge.
REQ-027 Combinational outputs pcsrcE and pctargetE SHALL follow their inputs regardless of rst.
REQ-028 Asserting rst mid-operation SHALL discard the in-flight instruction, with no write enables surviving the reset edge.

Verification
REQ-029 Add: rd1E=0x45, rd2E=0x46, alucontrolE=000, alusrcE=0, forwards 00, regwriteE=1, rdE=3 -> after 1 edge aluresultM=0x8B, regwriteM=1, rdM=3.
REQ-030 Forwarding: forwardAE=10, aluresultM_fwd=0x100, forwardBE=01, resultW=0x20, alucontrolE=001 -> aluresultM=0xE0, writedataM=0x20.
REQ-031 Branch taken: branchE=1, alucontrolE=001, rd1E=rd2E=0x50, pcE=0x40, immextendE=0xFFFFFFF8 -> same cycle pcsrcE=1, pctargetE=0x38; with rd2E=0x51 -> pcsrcE=0.
REQ-032 SLT: rd1E=0xFFFFFFFF, rd2E=1, alucontrolE=101 -> aluresultM=1; swapping the operands -> 0.
REQ-033 Store with flush: memwriteE=1, alusrcE=1, immextendE=4, rd2E=0x55, flushM=1 -> memwriteM=0, writedataM=0x55, aluresultM=rd1E+4.
REQ-034 Reset: rst=1 for one edge with all inputs nonzero -> all M outputs 0; the next edge without rst resumes normal capture.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, and branch/jump resolution.
// Also holds the EX/MEM pipeline register, which has a flush input for the control bits.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        regwriteE,
  input  logic        memwriteE,
  input  logic        jumpE,
  input  logic        branchE,
  input  logic        alusrcE,
  input  logic [1:0]  resultsrcE,
  input  logic [2:0]  alucontrolE,
  input  logic [31:0] pcE,
  input  logic [31:0] pcplus4E,
  input  logic [31:0] rd1E,
  input  logic [31:0] rd2E,
  input  logic [31:0] immextendE,
  input  logic [4:0]  rdE,
  input  logic [1:0]  forwardAE,
  input  logic [1:0]  forwardBE,
  input  logic [31:0] aluresultM_fwd,
  input  logic [31:0] resultW,
  input  logic        flushM,
  output logic        pcsrcE,
  output logic [31:0] pctargetE,
  output logic        regwriteM,
  output logic        memwriteM,
  output logic [1:0]  resultsrcM,
  output logic [31:0] aluresultM,
  output logic [31:0] writedataM,
  output logic [31:0] pcplus4M,
  output logic [4:0]  rdM
);

  logic [31:0] src_a;
  logic [31:0] fwd_b;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic        zero;

  // Select code 11 is unused by the hazard unit and falls back to the register value.
  always_comb begin
    case (forwardAE)
      2'b01:   src_a = resultW;
      2'b10:   src_a = aluresultM_fwd;
      default: src_a = rd1E;
    endcase
  end

  always_comb begin
    case (forwardBE)
      2'b01:   fwd_b = resultW;
      2'b10:   fwd_b = aluresultM_fwd;
      default: fwd_b = rd2E;
    endcase
  end

  assign src_b = alusrcE ? immextendE : fwd_b;

  always_comb begin
    case (alucontrolE)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b101:  alu_result = {31'b0, $signed(src_a) < $signed(src_b)};
      default: alu_result = 32'd0;
    endcase
  end

  assign zero      = (alu_result == 32'd0);
  assign pctargetE = pcE + immextendE;
  assign pcsrcE    = (branchE & zero) | jumpE;

  // Stores write the forwarded rs2 value, not the immediate-muxed ALU operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwriteM  <= 1'b0;
      memwriteM  <= 1'b0;
      resultsrcM <= 2'b00;
      aluresultM <= 32'd0;
      writedataM <= 32'd0;
      pcplus4M   <= 32'd0;
      rdM        <= 5'd0;
    end else begin
      aluresultM <= alu_result;
      writedataM <= fwd_b;
      pcplus4M   <= pcplus4E;
      rdM        <= rdE;
      if (flushM) begin
        regwriteM  <= 1'b0;
        memwriteM  <= 1'b0;
        resultsrcM <= 2'b00;
      end else begin
        regwriteM  <= regwriteE;
        memwriteM  <= memwriteE;
        resultsrcM <= resultsrcE;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: a behavioural model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_ex_stage;

  logic        clk;
  logic        rst;
  logic        regwriteE, memwriteE, jumpE, branchE, alusrcE;
  logic [1:0]  resultsrcE;
  logic [2:0]  alucontrolE;
  logic [31:0] pcE, pcplus4E, rd1E, rd2E, immextendE;
  logic [4:0]  rdE;
  logic [1:0]  forwardAE, forwardBE;
  logic [31:0] aluresultM_fwd, resultW;
  logic        flushM;
  logic        pcsrcE;
  logic [31:0] pctargetE;
  logic        regwriteM, memwriteM;
  logic [1:0]  resultsrcM;
  logic [31:0] aluresultM, writedataM, pcplus4M;
  logic [4:0]  rdM;

  int checks = 0;
  int errors = 0;

  ex_stage dut (
    .clk(clk), .rst(rst),
    .regwriteE(regwriteE), .memwriteE(memwriteE), .jumpE(jumpE), .branchE(branchE),
    .alusrcE(alusrcE), .resultsrcE(resultsrcE), .alucontrolE(alucontrolE),
    .pcE(pcE), .pcplus4E(pcplus4E), .rd1E(rd1E), .rd2E(rd2E), .immextendE(immextendE),
    .rdE(rdE), .forwardAE(forwardAE), .forwardBE(forwardBE),
    .aluresultM_fwd(aluresultM_fwd), .resultW(resultW), .flushM(flushM),
    .pcsrcE(pcsrcE), .pctargetE(pctargetE),
    .regwriteM(regwriteM), .memwriteM(memwriteM), .resultsrcM(resultsrcM),
    .aluresultM(aluresultM), .writedataM(writedataM), .pcplus4M(pcplus4M), .rdM(rdM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pickOperand(input logic [1:0] sel, input logic [31:0] regval);
    if (sel == 2'd1) return resultW;
    if (sel == 2'd2) return aluresultM_fwd;
    return regval;
  endfunction

  function automatic logic [31:0] aluModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int signed sa;
    int signed sb;
    sa = a;
    sb = b;
    if (op == 3'd0) return a + b;
    if (op == 3'd1) return a - b;
    if (op == 3'd2) return a & b;
    if (op == 3'd3) return a | b;
    if (op == 3'd5) return (sa < sb) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  function automatic logic [31:0] currentAlu();
    logic [31:0] b;
    b = alusrcE ? immextendE : pickOperand(forwardBE, rd2E);
    return aluModel(alucontrolE, pickOperand(forwardAE, rd1E), b);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model of the EX/MEM register contents, updated from the inputs seen at each edge.
  logic        modelValid = 1'b0;
  logic        expRegwrite, expMemwrite;
  logic [1:0]  expResultsrc;
  logic [31:0] expAlu, expWritedata, expPcplus4;
  logic [4:0]  expRd;

  always @(posedge clk) begin
    modelValid = 1'b1;
    if (rst) begin
      {expRegwrite, expMemwrite, expResultsrc} = '0;
      {expAlu, expWritedata, expPcplus4, expRd} = '0;
    end else begin
      expAlu       = currentAlu();
      expWritedata = pickOperand(forwardBE, rd2E);
      expPcplus4   = pcplus4E;
      expRd        = rdE;
      expRegwrite  = flushM ? 1'b0 : regwriteE;
      expMemwrite  = flushM ? 1'b0 : memwriteE;
      expResultsrc = flushM ? 2'b00 : resultsrcE;
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("mdl_regwriteM", 32'(regwriteM), 32'(expRegwrite));
      checkOutput("mdl_memwriteM", 32'(memwriteM), 32'(expMemwrite));
      checkOutput("mdl_resultsrcM", 32'(resultsrcM), 32'(expResultsrc));
      checkOutput("mdl_aluresultM", aluresultM, expAlu);
      checkOutput("mdl_writedataM", writedataM, expWritedata);
      checkOutput("mdl_pcplus4M", pcplus4M, expPcplus4);
      checkOutput("mdl_rdM", 32'(rdM), 32'(expRd));
      checkOutput("mdl_pctargetE", pctargetE, pcE + immextendE);
      checkOutput("mdl_pcsrcE", 32'(pcsrcE), 32'((branchE && currentAlu() == 32'd0) || jumpE));
    end
  end

  task automatic clearInputs();
    {regwriteE, memwriteE, jumpE, branchE, alusrcE, flushM} = '0;
    resultsrcE = 2'b00; alucontrolE = 3'b000;
    pcE = 32'd0; pcplus4E = 32'd0; rd1E = 32'd0; rd2E = 32'd0; immextendE = 32'd0;
    rdE = 5'd0; forwardAE = 2'b00; forwardBE = 2'b00;
    aluresultM_fwd = 32'd0; resultW = 32'd0;
  endtask

  // Inputs change 1 time unit after each rising edge, well clear of both sampling points.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clearInputs();
    rst = 1'b1;
    {regwriteE, memwriteE, jumpE, branchE, alusrcE, flushM} = 6'b111111;
    resultsrcE = 2'b11; alucontrolE = 3'b011;
    pcE = 32'h100; pcplus4E = 32'h104; rd1E = 32'h1234; rd2E = 32'h5678; immextendE = 32'h10;
    rdE = 5'd9; forwardAE = 2'b01; forwardBE = 2'b10; aluresultM_fwd = 32'h77; resultW = 32'h99;
    #1;
    checkOutput("rst_pctarget_comb", pctargetE, 32'h110);
    checkOutput("rst_jump_comb", 32'(pcsrcE), 32'd1);
    applyStimulus();
    checkOutput("rst_regwriteM", 32'(regwriteM), 32'd0);
    checkOutput("rst_memwriteM", 32'(memwriteM), 32'd0);
    checkOutput("rst_aluresultM", aluresultM, 32'd0);
    checkOutput("rst_pcplus4M", pcplus4M, 32'd0);
    checkOutput("rst_rdM", 32'(rdM), 32'd0);

    rst = 1'b0;
    clearInputs();
    rd1E = 32'h45; rd2E = 32'h46; regwriteE = 1'b1; rdE = 5'd3; pcplus4E = 32'h8;
    applyStimulus();
    checkOutput("add_aluresultM", aluresultM, 32'h8B);
    checkOutput("add_regwriteM", 32'(regwriteM), 32'd1);
    checkOutput("add_rdM", 32'(rdM), 32'd3);
    checkOutput("add_pcplus4M", pcplus4M, 32'h8);

    clearInputs();
    rd1E = 32'h1; rd2E = 32'h2; forwardAE = 2'b10; aluresultM_fwd = 32'h100;
    forwardBE = 2'b01; resultW = 32'h20; alucontrolE = 3'b001;
    applyStimulus();
    checkOutput("fwd_aluresultM", aluresultM, 32'hE0);
    checkOutput("fwd_writedataM", writedataM, 32'h20);

    clearInputs();
    branchE = 1'b1; alucontrolE = 3'b001; rd1E = 32'h50; rd2E = 32'h50;
    pcE = 32'h40; immextendE = 32'hFFFFFFF8;
    #1;
    checkOutput("br_taken_pcsrcE", 32'(pcsrcE), 32'd1);
    checkOutput("br_pctargetE", pctargetE, 32'h38);
    rd2E = 32'h51;
    #1;
    checkOutput("br_not_taken_pcsrcE", 32'(pcsrcE), 32'd0);
    jumpE = 1'b1;
    #1;
    checkOutput("jump_pcsrcE", 32'(pcsrcE), 32'd1);

    clearInputs();
    rd1E = 32'hFFFFFFFF; rd2E = 32'h1; alucontrolE = 3'b101;
    applyStimulus();
    checkOutput("slt_neg_lt_pos", aluresultM, 32'd1);
    rd1E = 32'h1; rd2E = 32'hFFFFFFFF;
    applyStimulus();
    checkOutput("slt_pos_lt_neg", aluresultM, 32'd0);

    clearInputs();
    memwriteE = 1'b1; regwriteE = 1'b1; resultsrcE = 2'b01; alusrcE = 1'b1;
    immextendE = 32'h4; rd1E = 32'h1000; rd2E = 32'h55; flushM = 1'b1;
    applyStimulus();
    checkOutput("flush_memwriteM", 32'(memwriteM), 32'd0);
    checkOutput("flush_regwriteM", 32'(regwriteM), 32'd0);
    checkOutput("flush_resultsrcM", 32'(resultsrcM), 32'd0);
    checkOutput("flush_writedataM", writedataM, 32'h55);
    checkOutput("flush_aluresultM", aluresultM, 32'h1004);

    clearInputs();
    rd1E = 32'hF0F0; rd2E = 32'h0FF0; alucontrolE = 3'b010; regwriteE = 1'b1; rdE = 5'd0;
    applyStimulus();
    checkOutput("and_aluresultM", aluresultM, 32'h00F0);
    checkOutput("x0_regwriteM", 32'(regwriteM), 32'd1);
    alucontrolE = 3'b011;
    applyStimulus();
    checkOutput("or_aluresultM", aluresultM, 32'hFFF0);
    alucontrolE = 3'b111;
    applyStimulus();
    checkOutput("bad_op_aluresultM", aluresultM, 32'd0);

    regwriteE = 1'b1; memwriteE = 1'b1; resultsrcE = 2'b10; flushM = 1'b1; rst = 1'b1;
    alucontrolE = 3'b000; rdE = 5'd7; pcplus4E = 32'hC;
    applyStimulus();
    checkOutput("midrst_regwriteM", 32'(regwriteM), 32'd0);
    checkOutput("midrst_memwriteM", 32'(memwriteM), 32'd0);
    checkOutput("midrst_aluresultM", aluresultM, 32'd0);
    rst = 1'b0; flushM = 1'b0;
    applyStimulus();
    checkOutput("resume_memwriteM", 32'(memwriteM), 32'd1);
    checkOutput("resume_resultsrcM", 32'(resultsrcM), 32'd2);
    checkOutput("resume_aluresultM", aluresultM, 32'h100E0);
    checkOutput("resume_rdM", 32'(rdM), 32'd7);

    for (int i = 0; i < 20; i++) begin
      rd1E = $urandom; rd2E = $urandom; immextendE = $urandom; pcE = $urandom;
      pcplus4E = $urandom; resultW = $urandom; aluresultM_fwd = $urandom;
      alucontrolE = 3'($urandom_range(0, 7)); forwardAE = 2'($urandom_range(0, 3));
      forwardBE = 2'($urandom_range(0, 3)); alusrcE = 1'($urandom_range(0, 1));
      {regwriteE, memwriteE, jumpE, branchE} = 4'($urandom_range(0, 15));
      resultsrcE = 2'($urandom_range(0, 3)); rdE = 5'($urandom_range(0, 31));
      flushM = ($urandom_range(0, 3) == 0);
      applyStimulus();
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
